// File: rtl/nlp16af_bus_responder.sv
// rtl/nlp16af_bus_responder.sv - nlp16af core memory-bus target: RAM, console FIFO, cycle counter, bus-error capture
//
// Ports:
//   i_clk, i_rst             clock (rising edge) and synchronous active-high reset
//   i_wr, i_rd               write / read strobes from the core
//   i_address, i_wdata       word address and write data from the core
//   o_rdata                  combinational read data (0 when not a clean read)
//   o_tx_valid, o_tx_data    console FIFO head; o_tx_data is 0x00 when empty
//   i_tx_ready               console sink accepts the head byte when high with o_tx_valid
//   o_bus_err                sticky bus-error flag
module nlp16af_bus_responder #(
    parameter int          RAM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] IO_BASE    = 16'hFF00
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wr,
    input  logic        i_rd,
    input  logic [15:0] i_address,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_ready,
    output logic        o_bus_err
);

    localparam int RAM_AW  = $clog2(RAM_WORDS);
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = FIFO_AW + 1;

    localparam logic [16:0]      RAM_LIMIT  = 17'(RAM_WORDS);
    localparam logic [CNT_W-1:0] FIFO_FULL  = CNT_W'(FIFO_DEPTH);

    localparam logic [7:0] OFF_CON_DATA   = 8'h00;
    localparam logic [7:0] OFF_CON_STATUS = 8'h01;
    localparam logic [7:0] OFF_CYCLE_LO   = 8'h02;
    localparam logic [7:0] OFF_CYCLE_HI   = 8'h03;
    localparam logic [7:0] OFF_BUS_ERR    = 8'h04;

    // Storage
    logic [15:0]        r_ram [RAM_WORDS];
    logic [7:0]         r_fifo [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;
    logic [31:0]        r_counter;
    logic [15:0]        r_shadow;
    logic [15:0]        r_err_addr;
    logic               r_bus_err;

    // Address decode
    logic [15:0]       w_io_off;
    logic [7:0]        w_io_reg;
    logic              w_in_ram;
    logic              w_in_page;
    logic              w_in_io;
    logic              w_mapped;
    logic              w_err;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic [RAM_AW-1:0] w_ram_idx;

    assign w_io_off  = i_address - IO_BASE;
    assign w_io_reg  = w_io_off[7:0];
    assign w_in_ram  = ({1'b0, i_address} < RAM_LIMIT);
    assign w_in_page = (i_address >= IO_BASE) && (w_io_off[15:8] == 8'h00);
    assign w_in_io   = w_in_page && (w_io_reg <= OFF_BUS_ERR);
    assign w_mapped  = w_in_ram || w_in_io;
    assign w_ram_idx = i_address[RAM_AW-1:0];

    // A conflicting strobe pair is an error even at a mapped address, and an
    // erroring access must not touch any state, so both gates exclude it.
    assign w_err   = (i_wr || i_rd) && (!w_mapped || (i_wr && i_rd));
    assign w_wr_ok = i_wr && !i_rd && w_mapped;
    assign w_rd_ok = i_rd && !i_wr && w_mapped;

    logic w_wr_io;
    logic w_wr_con_data;
    logic w_wr_con_status;
    logic w_wr_cycle_lo;
    logic w_wr_bus_err;
    logic w_rd_cycle_lo;

    assign w_wr_io         = w_wr_ok && w_in_io;
    assign w_wr_con_data   = w_wr_io && (w_io_reg == OFF_CON_DATA);
    assign w_wr_con_status = w_wr_io && (w_io_reg == OFF_CON_STATUS);
    assign w_wr_cycle_lo   = w_wr_io && (w_io_reg == OFF_CYCLE_LO);
    assign w_wr_bus_err    = w_wr_io && (w_io_reg == OFF_BUS_ERR);
    assign w_rd_cycle_lo   = w_rd_ok && w_in_io && (w_io_reg == OFF_CYCLE_LO);

    // FIFO control
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_overflow_set;

    assign w_full  = (r_count == FIFO_FULL);
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && i_tx_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign w_push         = w_wr_con_data && (!w_full || w_pop);
    assign w_overflow_set = w_wr_con_data && w_full && !w_pop;

    // RAM: asynchronous read, synchronous write, contents survive reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_wr_ok && w_in_ram) begin
            r_ram[w_ram_idx] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && w_push) begin
            r_fifo[r_wr_ptr] <= i_wdata[7:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_overflow_set) begin
                r_overflow <= 1'b1;
            end else if (w_wr_con_status && i_wdata[2]) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Cycle counter; reading CYCLE_LO snapshots the upper half so that a
    // following CYCLE_HI read is coherent with the low half already returned.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_counter <= '0;
            r_shadow  <= '0;
        end else begin
            if (w_wr_cycle_lo) begin
                r_counter <= '0;
            end else begin
                r_counter <= r_counter + 32'd1;
            end
            if (w_rd_cycle_lo) begin
                r_shadow <= r_counter[31:16];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err_addr <= '0;
            r_bus_err  <= 1'b0;
        end else if (w_err) begin
            r_err_addr <= i_address;
            r_bus_err  <= 1'b1;
        end else if (w_wr_bus_err) begin
            r_bus_err  <= 1'b0;
        end
    end

    // Read mux
    logic [7:0]  w_count8;
    logic [15:0] w_rdata;

    assign w_count8 = 8'(r_count);

    always_comb begin
        w_rdata = 16'h0000;
        if (!i_rst && w_rd_ok) begin
            if (w_in_ram) begin
                w_rdata = r_ram[w_ram_idx];
            end else begin
                case (w_io_reg)
                    OFF_CON_STATUS: w_rdata = {w_count8, 5'b00000, r_overflow, w_empty, w_full};
                    OFF_CYCLE_LO:   w_rdata = r_counter[15:0];
                    OFF_CYCLE_HI:   w_rdata = r_shadow;
                    OFF_BUS_ERR:    w_rdata = r_err_addr;
                    default:        w_rdata = 16'h0000;
                endcase
            end
        end
    end

    assign o_rdata    = w_rdata;
    assign o_tx_valid = !w_empty;
    assign o_tx_data  = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
    assign o_bus_err  = r_bus_err;

endmodule

// File: doc/nlp16af_bus_responder.md
Name: nlp16af_bus_responder

Overview:
- Target side of the nlp16af core memory bus. Decodes the core's address and read/write strobes into on-chip RAM and a small I/O page.
- I/O page holds a console TX FIFO with valid/ready output, a 32-bit cycle counter and a bus-error capture register.
- Read data is returned in the same cycle as the strobe, because the core samples its input bus in the cycle it drives rd. Writes commit on the next rising edge.

Parameters:
- RAM_WORDS, 1024: 16-bit RAM words at 0x0000..RAM_WORDS-1. Power of two, ≤ IO_BASE.
- FIFO_DEPTH, 8: console FIFO entries. Power of two, ≥ 2.
- IO_BASE, 16'hFF00: base of the I/O page.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_wr  in  1  write strobe from core.
- i_rd  in  1  read strobe from core.
- i_address  in  16  word address from core.
- i_wdata  in  16  write data from core.
- o_rdata  out  16  read data to core (combinational).
- o_tx_valid  out  1  console byte available.
- o_tx_data  out  8  FIFO head byte; 0x00 when empty.
- i_tx_ready  in  1  console sink accepts the byte when o_tx_valid && i_tx_ready.
- o_bus_err  out  1  sticky bus-error flag.

Behaviour:
- Reset (i_rst sampled high at an edge):
  - FIFO becomes empty, counter = 0, shadow = 0, overflow = 0, err_addr = 0, o_bus_err = 0.
  - Any write or pop in that cycle is ignored, including RAM writes.
  - While i_rst is high, o_rdata = 0. RAM contents are not reset.
- Read path:
  - o_rdata is a mux of the decoded source when i_rd=1 and i_wr=0; otherwise 0x0000.
  - Unmapped reads return 0x0000.
- Address map (offsets relative to IO_BASE):
  - 0x0000..RAM_WORDS-1, RAM: asynchronous read; write on edge when i_wr.
  - +0 CONSOLE_DATA: write pushes i_wdata[7:0]; read returns 0.
  - +1 CONSOLE_STATUS, read: [0] full, [1] empty, [2] overflow, [15:8] occupancy count. Write with i_wdata[2]=1 clears overflow.
  - +2 CYCLE_LO: read returns counter[15:0] and, at that edge, loads shadow ← counter[31:16]. Write clears the counter to 0; clear wins over increment.
  - +3 CYCLE_HI: read returns shadow; writes ignored.
  - +4 BUS_ERR: read returns err_addr; write clears o_bus_err (err_addr kept).
  - RAM_WORDS..IO_BASE-1 and +5..0xFF: unmapped.
- Bus error:
  - Triggers: a strobe to an unmapped address, or i_wr && i_rd together.
  - Effect: err_addr ← i_address and o_bus_err ← 1 on the next edge; no state change to any register or RAM.
  - If an error occurs in the same cycle as a BUS_ERR clear write, the error wins.
- Counter:
  - +1 every non-reset cycle.
  - 32-bit, wraps 0xFFFFFFFF→0.
- FIFO:
  - Circular buffer with read/write pointers and a count (0..FIFO_DEPTH).
  - pop = o_tx_valid && i_tx_ready. push = valid write to CONSOLE_DATA.
  - Push while full and no pop in the same cycle: byte dropped, overflow ← 1 (sticky).
  - Push while full with a pop in the same cycle: push accepted, count unchanged.
  - Push while empty: byte appears on o_tx_data with o_tx_valid=1 the next cycle. No fall-through in the same cycle.
  - Simultaneous push and pop when not empty: count unchanged, order preserved.
- Multi-cycle strobes: each cycle a strobe is held is a separate access. A held CONSOLE_DATA write pushes once per cycle.
- Latency summary: read 0 cycles, write 1 edge, FIFO push→visible 1 edge.

Test Plan:
- Reset, then write 0x1234 to 0x0005 and read 0x0005 → o_rdata=0x1234 the next cycle. Read 0x0006 after writing 0xBEEF → 0xBEEF; o_bus_err stays 0.
- Hold i_tx_ready=0; write 0x41,0x42,… ×9 to 0xFF00 (FIFO_DEPTH=8) → STATUS=0x0805 (count 8, full, overflow). Raise ready → 8 bytes 0x41..0x48 popped in order, then o_tx_valid=0 and STATUS=0x0006.
- FIFO full with ready=1, push 0x55 in the same cycle as a pop → count stays 8, overflow stays 0, 0x55 is the last byte out.
- Read 0xFF02 at counter=0x0001FFFE → o_rdata=0xFFFE. Next cycle read 0xFF03 → 0x0001, even though the counter has advanced. Write 0xFF02 → counter reads 0x0000+n afterwards.
- Read 0x8000 (RAM_WORDS=1024) → o_rdata=0, o_bus_err=1 next cycle, BUS_ERR reads 0x8000. Assert i_wr && i_rd at 0x0003 → RAM[3] unchanged, err_addr=0x0003. Write 0xFF04 → o_bus_err=0.
- Assert i_rst mid-transfer with FIFO count 3 and a RAM write pending → after reset FIFO empty, o_tx_valid=0, counter=0, RAM word not written.
